if_prefetch_queue: RTL

- Instruction prefetch buffer between the synchronous instruction memory and the ID stage.
- Owns the fetch PC and issues one sequential fetch per cycle while credit is available.
- Buffers returned instructions with their PC/NPC and presents the queue head to ID as IR/NPC.
- Holds under hazard stall; flushes and redirects on a taken branch from EX.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 85 ++++++++
 rtl/if_prefetch_queue.sv | 109 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants: machine width, instruction size,
// the idle instruction value and the entry format carried by the fetch queue.
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int INSN_BYTES = 4;

  localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
  } fetch_entry_t;

  // Instruction fetches are always word addressed; low address bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched instructions with a combinational head view.
// Flush empties the buffer in one cycle and takes priority over push/pop.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_ni,
  input  logic          push_i,
  input  fetch_entry_t  push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  fetch_entry_t mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic empty;
  logic full;
  logic do_pop;
  logic do_push;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_COUNT);
  assign do_pop  = pop_i && !empty && !flush_i;
  // A push into a full buffer is only accepted when a pop frees the slot.
  assign do_push = push_i && !flush_i && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CW'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = empty;

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues one sequential fetch per
// cycle while credit remains, buffers responses and presents the head to decode.
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = cpu_pkg::NOP_INSN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        valid_o,
  output logic [31:0] ir_o,
  output logic [31:0] pc_o,
  output logic [31:0] npc_o
);

  import cpu_pkg::*;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0]     DEPTH_OCC = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(INSN_BYTES);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic            epoch_q, epoch_d;
  logic            req_epoch_q, req_epoch_d;
  logic            inflight_q, inflight_d;

  fetch_entry_t  head;
  fetch_entry_t  resp_entry;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [CW:0]   occupancy;
  logic          credit_ok;
  logic          issue;
  logic          resp_push;
  logic          head_pop;

  // Credit counts the outstanding fetch but ignores a same-cycle pop, so the
  // buffer can never be overrun by a response.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign credit_ok = (occupancy < DEPTH_OCC);
  assign issue     = !redirect && credit_ok;

  assign resp_push  = inflight_q && (req_epoch_q == epoch_q) && !redirect;
  assign resp_entry = '{insn: imem_rdata, pc: req_addr_q};
  assign head_pop   = !fifo_empty && !stall && !redirect;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    req_addr_d  = req_addr_q;
    req_epoch_d = req_epoch_q;
    epoch_d     = epoch_q ^ redirect;
    inflight_d  = issue;
    if (redirect) begin
      fetch_pc_d = word_align(redirect_pc);
    end else if (issue) begin
      fetch_pc_d  = fetch_pc_q + PC_STEP;
      req_addr_d  = fetch_pc_q;
      req_epoch_d = epoch_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q  <= word_align(RESET_PC);
      req_addr_q  <= '0;
      epoch_q     <= 1'b0;
      req_epoch_q <= 1'b0;
      inflight_q  <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      req_addr_q  <= req_addr_d;
      epoch_q     <= epoch_d;
      req_epoch_q <= req_epoch_d;
      inflight_q  <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_ni      (rst),
    .push_i      (resp_push),
    .push_data_i (resp_entry),
    .pop_i       (head_pop),
    .flush_i     (redirect),
    .head_o      (head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  // The request is masked while reset is held so memory sees no fetch then.
  assign imem_req  = issue && rst;
  assign imem_addr = fetch_pc_q;

  assign valid_o = !fifo_empty;
  assign ir_o    = valid_o ? head.insn : NOP_INSN;
  assign pc_o    = valid_o ? head.pc : '0;
  assign npc_o   = valid_o ? (head.pc + PC_STEP) : '0;

endmodule
